lab1_imul_var_lat_mul: RTL and testbench
========================================

// Module: lab1_imul_var_lat_mul
// PURPOSE
//  Variable-latency iterative 32x32 multiplier; consumes per-cycle shift amounts
//  from the trailing-zero priority encoder to skip runs of zero bits in operand b.
//  Sits between the imul test source (req) and sink (resp) behind val/rdy
//  handshakes. Returns the low 32 bits of a*b (mod 2^32, sign-agnostic).
// PARAMETERS
//  P_NBITS   32   operand/result width; only 32 supported (encoder is fixed 32-bit)
// PORTS
//  clk        in   1   clock, all state rising-edge
//  reset      in   1   asynchronous, active-high
//  req_val    in   1   request valid
//  req_rdy    out  1   request ready
//  req_msg    in   64  {a[63:32], b[31:0]}
//  resp_val   out  1   response valid
//  resp_rdy   in   1   response ready
//  resp_msg   out  32  product low 32 bits
// BEHAVIOUR
//  - Reset (async): state=IDLE, a_reg=b_reg=result_reg=0; resp_val=0,
//    resp_msg=0; req_rdy=0 while reset high, 1 first cycle after deassertion.
//  - FSM states IDLE, CALC, DONE. Outputs decoded from state only (Moore):
//    req_rdy=(IDLE & !reset), resp_val=DONE, resp_msg=result_reg.
//  - IDLE: req_val&req_rdy -> latch a,b; result_reg=0; -> CALC.
//  - CALC, each cycle: if b_reg[0] result_reg += a_reg (wraps mod 2^32).
//    sa = encoder(b_reg) = index of lowest set bit in b_reg[31:1], 0 if none.
//    sa==0 -> DONE (add above still committed); else a_reg<<=sa, b_reg>>=sa.
//  - DONE: hold resp_msg; resp_val&resp_rdy -> IDLE. resp_rdy low stalls
//    indefinitely with resp_msg stable. No new request accepted until IDLE.
//  - CALC cycles = 1 + popcount(b[31:1]); b=0 or b=1 -> 1 cycle.
//    Req-accept edge to resp_val high = 1 + CALC cycles (min 2, max 33).
//  - Shifts discard bits beyond 32; a_reg overflow is harmless (mod 2^32).
//  - Reset asserted mid-CALC/DONE: immediate return to IDLE, in-flight
//    transaction dropped, resp_val falls asynchronously.
//  - resp_val and req_rdy never both high.
// CONFIGURATION
//  LAB1_IMUL_FIXED_LAT_EN
//   defined:   encoder bypassed; sa forced to 1 each CALC cycle, exit after
//              exactly 32 CALC cycles (5-bit iteration counter, reset 0);
//              latency fixed at 33 cycles regardless of b.
//   undefined: variable latency as above; no iteration counter.
//   Product value identical in both modes.
// STRUCTURE
//  - Shared package lab1_imul_pkg: state enum (IDLE/CALC/DONE, 2 bits),
//    req/resp message field widths and bit ranges, NBITS=32 constant.
//  - Sub-module lab1_imul_var_lat_dpath: a/b/result registers, adder, two
//    barrel shifters, encoder instance; exports b_reg[0] and sa to control.
//  - Control FSM stays in this top module.
// TESTING
//  - a=3,b=4 -> resp_msg=12; 2 CALC cycles; resp_val 3 cycles after accept.
//  - a=0xDEADBEEF,b=0 -> resp_msg=0 after 1 CALC cycle; a=7,b=1 -> 7.
//  - a=0xFFFFFFFF,b=0xFFFFFFFF -> resp_msg=0x00000001; 32 CALC cycles;
//    a=-5,b=6 -> 0xFFFFFFE2.
//  - a=9,b=9, resp_rdy low 10 cycles -> resp_val held, resp_msg=81 stable,
//    req_rdy=0 throughout; back-to-back second req accepted cycle after drain.
//  - reset pulsed mid-CALC of a=5,b=0x80000001 -> resp_val=0, req_rdy=1 after
//    deassert; next a=2,b=3 -> 6.
//  - LAB1_IMUL_FIXED_LAT_EN: a=3,b=4 -> 12 with exactly 33-cycle latency.

Source files
------------

// File: rtl/lab1_imul_pkg.sv
// Shared types and constants for the imul variable-latency multiplier.
package lab1_imul_pkg;

  localparam int NBITS     = 32;
  localparam int SA_W      = 5;
  localparam int REQ_W     = 2*NBITS;
  localparam int RESP_W    = NBITS;
  localparam int REQ_A_MSB = 63;
  localparam int REQ_A_LSB = 32;
  localparam int REQ_B_MSB = 31;
  localparam int REQ_B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Trailing-zero priority encoder: index of lowest set bit in b[31:1], 0 if none.
  function automatic logic [SA_W-1:0] tz_enc(input logic [NBITS-1:0] b);
    logic [SA_W-1:0] sa;
    sa = '0;
    for (int i = NBITS-1; i >= 1; i--)
      if (b[i]) sa = i[SA_W-1:0];
    return sa;
  endfunction

endpackage

// File: rtl/lab1_imul_var_lat_dpath.sv
// Datapath: operand/result registers, accumulate adder, barrel shifters and
// the zero-skip encoder. With LAB1_IMUL_FIXED_LAT_EN the encoder is bypassed
// and every iteration shifts by exactly one.
module lab1_imul_var_lat_dpath
  import lab1_imul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              calc,
  input  logic [REQ_W-1:0]  req_msg,
  output logic              b_lsb,
  output logic [SA_W-1:0]   sa,
  output logic [NBITS-1:0]  result
);

  logic [NBITS-1:0] a_reg, b_reg, result_reg;

`ifdef LAB1_IMUL_FIXED_LAT_EN
  assign sa = SA_W'(1);
`else
  assign sa = tz_enc(b_reg);
`endif

  assign b_lsb  = b_reg[0];
  assign result = result_reg;

  // Latch operands on accept; each CALC cycle add then skip the zero run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else if (load) begin
      a_reg      <= req_msg[REQ_A_MSB:REQ_A_LSB];
      b_reg      <= req_msg[REQ_B_MSB:REQ_B_LSB];
      result_reg <= '0;
    end else if (calc) begin
      if (b_reg[0]) result_reg <= result_reg + a_reg;
      a_reg <= a_reg << sa;
      b_reg <= b_reg >> sa;
    end
  end

endmodule

// File: rtl/lab1_imul_var_lat_mul.sv
// Iterative 32x32 multiplier (low 32 bits) behind val/rdy handshakes.
// Control FSM lives here; datapath in lab1_imul_var_lat_dpath.
// Config macro: LAB1_IMUL_FIXED_LAT_EN forces 32 CALC cycles per product.
module lab1_imul_var_lat_mul
  import lab1_imul_pkg::*;
#(
  parameter int P_NBITS = 32
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [2*P_NBITS-1:0] req_msg,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [P_NBITS-1:0]   resp_msg
);

  state_t          state;
  logic            load, calc, b_lsb;
  logic [SA_W-1:0] sa;

  assign req_rdy  = (state == IDLE) && !reset;
  assign resp_val = (state == DONE);
  assign load     = req_val && req_rdy;
  assign calc     = (state == CALC);

  lab1_imul_var_lat_dpath u_dpath (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .calc    (calc),
    .req_msg (req_msg),
    .b_lsb   (b_lsb),
    .sa      (sa),
    .result  (resp_msg)
  );

`ifdef LAB1_IMUL_FIXED_LAT_EN
  logic [SA_W-1:0] iter;

  // Control: accept, run exactly 32 iterations, hold result until drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      iter  <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin state <= CALC; iter <= '0; end
        CALC: if (iter == SA_W'(NBITS-1)) state <= DONE;
              else iter <= iter + SA_W'(1);
        DONE: if (resp_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Control: accept, iterate until no set bits remain above b[0], hold until drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (load) state <= CALC;
        CALC: if (sa == '0) state <= DONE;
        DONE: if (resp_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_lab1_imul_var_lat_mul.sv
// Self-checking bench for lab1_imul_var_lat_mul: directed cases, stall,
// back-to-back, mid-flight reset and randomized operands vs. a plain a*b model.
module tb_lab1_imul_var_lat_mul;

  logic        clk = 0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [63:0] req_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg;

  int tests = 0;
  int fails = 0;

  lab1_imul_var_lat_mul dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  always #5 clk = ~clk;

  // Reference: product mod 2^32 and the number of CALC cycles it should take.
  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  function automatic int ref_calc(input logic [31:0] b);
`ifdef LAB1_IMUL_FIXED_LAT_EN
    return 32;
`else
    return 1 + $countones(b[31:1]);
`endif
  endfunction

  // Handshakes must never overlap.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      tests++;
      if (resp_val && req_rdy) begin
        fails++;
        $display("FAIL handshake_overlap: resp_val=%b req_rdy=%b (required not both 1)", resp_val, req_rdy);
      end
    end
  end

  // Drive one transaction with resp_rdy high; lat = cycles from accept cycle
  // (counted as 1) until resp_val observed. Called right after posedge+#1.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit to);
    int n;
    n = 0;
    to = 0;
    req_msg = {a, b};
    req_val = 1;
    resp_rdy = 1;
    while (!req_rdy && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_val = 0;
    lat = 1;
    while (!resp_val && lat < 100) begin @(posedge clk); #1; lat++; end
    res = resp_msg;
    to = !resp_val || (n >= 100);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; req_val = 0; resp_rdy = 0; req_msg = '0;
    #1;
    tests++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b0 || resp_msg !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: resp_val=%b req_rdy=%b resp_msg=%h (required 0 0 00000000)", resp_val, req_rdy, resp_msg);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    #1;
    tests++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: req_rdy=%b resp_val=%b (required 1 0)", req_rdy, resp_val);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] av [6];
    logic [31:0] bv [6];
    logic [31:0] res;
    int lat;
    bit to;
    av = '{32'd3, 32'hDEADBEEF, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'd0};
    bv = '{32'd4, 32'd0,        32'd1, 32'hFFFFFFFF, 32'd6,        32'h12345678};
    for (int i = 0; i < 6; i++) begin
      run_txn(av[i], bv[i], res, lat, to);
      tests++;
      if (to || res !== ref_prod(av[i], bv[i])) begin
        fails++;
        $display("FAIL directed_prod[%0d]: got %h timeout=%0d (required %h)", i, res, to, ref_prod(av[i], bv[i]));
      end
      tests++;
      if (lat != 1 + ref_calc(bv[i])) begin
        fails++;
        $display("FAIL directed_lat[%0d]: got %0d (required %0d)", i, lat, 1 + ref_calc(bv[i]));
      end
    end
  endtask

  task automatic test_stall_back_to_back();
    int lat;
    bit bad;
    lat = 0;
    req_msg = {32'd9, 32'd9};
    req_val = 1;
    resp_rdy = 0;
    @(posedge clk); #1;               // accepted (req_rdy was 1)
    req_msg = {32'd4, 32'd5};         // second request waits during stall
    while (!resp_val && lat < 100) begin @(posedge clk); #1; lat++; end
    bad = (lat >= 100);
    for (int i = 0; i < 10; i++) begin
      if (resp_val !== 1'b1 || resp_msg !== 32'd81 || req_rdy !== 1'b0) bad = 1;
      @(posedge clk); #1;
    end
    tests++;
    if (bad || resp_val !== 1'b1 || resp_msg !== 32'd81) begin
      fails++;
      $display("FAIL stall_hold: resp_val=%b resp_msg=%0d req_rdy=%b (required 1 81 0 throughout)", resp_val, resp_msg, req_rdy);
    end
    resp_rdy = 1;
    @(posedge clk); #1;               // drain
    tests++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      fails++;
      $display("FAIL drain_rdy: req_rdy=%b resp_val=%b (required 1 0)", req_rdy, resp_val);
    end
    @(posedge clk); #1;               // second request accepted
    req_val = 0;
    tests++;
    if (req_rdy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: req_rdy=%b (required 0 after accept)", req_rdy);
    end
    lat = 1;
    while (!resp_val && lat < 100) begin @(posedge clk); #1; lat++; end
    tests++;
    if (resp_msg !== 32'd20 || lat != 1 + ref_calc(32'd5)) begin
      fails++;
      $display("FAIL b2b_result: got %0d lat %0d (required 20 lat %0d)", resp_msg, lat, 1 + ref_calc(32'd5));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    bit to;
    req_msg = {32'd5, 32'h80000001};
    req_val = 1;
    resp_rdy = 1;
    @(posedge clk); #1;               // accepted
    req_val = 0;
    @(posedge clk); #1;               // mid-CALC
    reset = 1;
    #1;
    tests++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_assert: resp_val=%b req_rdy=%b (required 0 0)", resp_val, req_rdy);
    end
    @(posedge clk); #1;
    reset = 0;
    #1;
    tests++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_release: req_rdy=%b resp_val=%b (required 1 0)", req_rdy, resp_val);
    end
    @(posedge clk); #1;
    run_txn(32'd2, 32'd3, res, lat, to);
    tests++;
    if (to || res !== 32'd6) begin
      fails++;
      $display("FAIL reset_mid_next: got %0d (required 6)", res);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res;
    int lat;
    bit to;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom & ($urandom >> $urandom_range(0, 31));
      run_txn(a, b, res, lat, to);
      tests++;
      if (to || res !== ref_prod(a, b) || lat != 1 + ref_calc(b)) begin
        fails++;
        $display("FAIL random[%0d]: a=%h b=%h got %h lat %0d (required %h lat %0d)",
                 i, a, b, res, lat, ref_prod(a, b), 1 + ref_calc(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
